ball_motion_ctrl: RTL
=====================

Name: ball_motion_ctrl

Overview:
- Parametrised successor to the single-speed ball mover.
- Owns ball position and velocity for one ball: keyboard direction and speed control, pause, edge reflection, start-up idle state.
- All logic runs on the system clock; frame timing comes from VGA vsync.
- Sits between the USB keycode path and color_mapper/collision logic.

Parameters:
- COORD_W, 10, coordinate width
- X_MIN, 0, left bound (pixels)
- X_MAX, 639, right bound
- Y_MIN, 0, top bound
- Y_MAX, 479, bottom bound
- X_START, 320, reset X centre
- Y_START, 240, reset Y centre
- BALL_SIZE, 4, radius (pixels)
- SPEED_W, 4, speed magnitude width
- SPEED_INIT, 1, reset speed
- SPEED_MAX, 8, speed ceiling (speed floor fixed at 1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_vs  in  1  VGA vsync, asynchronous to Clk; frame boundary is its rising edge
- keycode  in  8  USB HID keycode, 0 = none
- ball_x  out  COORD_W  centre X
- ball_y  out  COORD_W  centre Y
- ball_size  out  COORD_W  constant BALL_SIZE
- vel_x  out  SPEED_W+1  signed X velocity (px/frame)
- vel_y  out  SPEED_W+1  signed Y velocity
- speed  out  SPEED_W  current magnitude
- bounce  out  1  one-Clk pulse on any reflection
- moving  out  1  high in RUN

Behaviour:
- Reset (async): ball_x=X_START, ball_y=Y_START, vel=0/0, speed=SPEED_INIT, bounce=0, moving=0, state=IDLE, pending direction=none, sync flops=0.
- frame_vs passes through a 2-flop synchroniser, then an edge register.
- tick = sync2 & ~prev. The update occurs on the Clk edge where tick is high, so outputs change on the 3rd rising Clk edge after frame_vs rises.
- Key press = keycode differs from previous-cycle keycode and is nonzero. Held keys never repeat.
- Direction keys: 0x1A (W) up, 0x16 (S) down, 0x04 (A) left, 0x07 (D) right.
  - A press stores a pending direction (unit dx, dy ∈ {-1, 0, +1}). Last press before a tick wins.
  - A press in the same cycle as tick is applied at that tick.
- 0x2E (=): speed+1, saturating at SPEED_MAX.
- 0x2D (-): speed-1, saturating at 1.
  - Speed changes take effect immediately in the register; the velocity recomputes at the next tick.
- 0x2C (space): toggles RUN<->PAUSE. Ignored in IDLE.
- States:
  - IDLE: stationary. A pending direction at a tick -> RUN, applied that tick.
  - RUN: at each tick:
    - if pending, vel = dir*speed and clear pending; else vel = sign(vel)*speed;
    - then position += vel with reflection.
  - PAUSE: position and velocity held; pending still accumulates; space -> RUN.
- Reflection per axis, computed in COORD_W+2 signed arithmetic (no wrap):
  - if next+BALL_SIZE > MAX: pos = MAX-BALL_SIZE, vel negated;
  - if next-BALL_SIZE < MIN: pos = MIN+BALL_SIZE, vel negated.
  - Both axes may reflect in one tick; bounce still pulses exactly once that cycle.
- vel_x/vel_y are registered and change only at ticks, or at reset.
- moving = (state==RUN).

Optional Feature:
- DIAG_KEYS_EN defined: adds diagonal keys 0x14 (Q) up-left, 0x08 (E) up-right, 0x1D (Z) down-left, 0x06 (C) down-right. Each sets both components to ±speed, handled like other direction keys.
- Undefined: those codes are ignored; only axis-aligned motion is possible.

Test Plan:
- Reset then 3 vs pulses, no key -> ball (320,240), vel 0/0, moving=0.
- keycode 0x07 held across 4 ticks -> RUN after first tick, ball_x 321,322,323,324, single pending consumed; holding key gives no repeat.
- Press = three times then D, run 2 ticks -> speed=4, ball_x 324 then 328. Press = ten times -> speed stays 8.
- Right edge: ball at x=634 moving +8 -> next tick ball_x=635, vel_x=-8, bounce high exactly 1 Clk. Same setup in a corner -> both vel negated, one bounce pulse.
- Space mid-run -> position frozen over 5 ticks. Press A during pause, then space -> next tick vel_x=-speed.
- Assert Reset asynchronously between Clk edges mid-RUN -> outputs return to reset values immediately, no bounce pulse.

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Single-ball position/velocity controller: keyboard direction, speed and pause,
// edge reflection on vsync ticks. Define DIAG_KEYS_EN to enable Q/E/Z/C diagonal keys.
module ball_motion_ctrl #(
  parameter int COORD_W    = 10,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 639,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 479,
  parameter int X_START    = 320,
  parameter int Y_START    = 240,
  parameter int BALL_SIZE  = 4,
  parameter int SPEED_W    = 4,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_vs,
  input  logic [7:0]                keycode,
  output logic [COORD_W-1:0]        ball_x,
  output logic [COORD_W-1:0]        ball_y,
  output logic [COORD_W-1:0]        ball_size,
  output logic signed [SPEED_W:0]   vel_x,
  output logic signed [SPEED_W:0]   vel_y,
  output logic [SPEED_W-1:0]        speed,
  output logic                      bounce,
  output logic                      moving
);

  localparam int CW2 = COORD_W + 2;
  localparam logic signed [CW2-1:0] X_HI = CW2'(X_MAX - BALL_SIZE);
  localparam logic signed [CW2-1:0] X_LO = CW2'(X_MIN + BALL_SIZE);
  localparam logic signed [CW2-1:0] Y_HI = CW2'(Y_MAX - BALL_SIZE);
  localparam logic signed [CW2-1:0] Y_LO = CW2'(Y_MIN + BALL_SIZE);

  typedef logic signed [SPEED_W:0] vel_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2} state_t;

  // {valid, dx, dy}; dx/dy are 2-bit two's complement unit steps
  function automatic logic [4:0] decode_dir(input logic [7:0] code);
    case (code)
      8'h1A:   decode_dir = {1'b1, 2'b00, 2'b11};
      8'h16:   decode_dir = {1'b1, 2'b00, 2'b01};
      8'h04:   decode_dir = {1'b1, 2'b11, 2'b00};
      8'h07:   decode_dir = {1'b1, 2'b01, 2'b00};
`ifdef DIAG_KEYS_EN
      8'h14:   decode_dir = {1'b1, 2'b11, 2'b11};
      8'h08:   decode_dir = {1'b1, 2'b01, 2'b11};
      8'h1D:   decode_dir = {1'b1, 2'b11, 2'b01};
      8'h06:   decode_dir = {1'b1, 2'b01, 2'b01};
`endif
      default: decode_dir = 5'b00000;
    endcase
  endfunction

  function automatic vel_t scale_dir(input logic [1:0] d, input logic [SPEED_W-1:0] s);
    vel_t mag;
    mag = {1'b0, s};
    case (d)
      2'b01:   scale_dir = mag;
      2'b11:   scale_dir = -mag;
      default: scale_dir = '0;
    endcase
  endfunction

  function automatic logic [1:0] sign_of(input vel_t v);
    if (v[SPEED_W]) begin
      sign_of = 2'b11;
    end else if (v != '0) begin
      sign_of = 2'b01;
    end else begin
      sign_of = 2'b00;
    end
  endfunction

  // {hit, new_vel, new_pos}; widened signed sum so the edge test never wraps
  function automatic logic [COORD_W+SPEED_W+1:0] reflect(
      input logic [COORD_W-1:0] pos, input vel_t v,
      input logic signed [CW2-1:0] lo, input logic signed [CW2-1:0] hi);
    logic signed [CW2-1:0] nxt;
    vel_t neg;
    nxt = $signed({2'b00, pos}) + $signed({{(CW2-SPEED_W-1){v[SPEED_W]}}, v});
    neg = -v;
    if (nxt > hi) begin
      reflect = {1'b1, neg, hi[COORD_W-1:0]};
    end else if (nxt < lo) begin
      reflect = {1'b1, neg, lo[COORD_W-1:0]};
    end else begin
      reflect = {1'b0, v, nxt[COORD_W-1:0]};
    end
  endfunction

  logic                sync1_r, sync2_r, prev_r;
  logic [7:0]          key_prev_r;
  state_t              state_r, state_s;
  logic                pend_valid_r;
  logic [1:0]          pend_dx_r, pend_dy_r;
  logic [COORD_W-1:0]  ball_x_r, ball_y_r;
  vel_t                vel_x_r, vel_y_r;
  logic [SPEED_W-1:0]  speed_r;
  logic                bounce_r, moving_r;

  logic                tick_s, press_s, dir_press_s, pend_any_s, step_s;
  logic                space_s, inc_s, dec_s;
  logic [4:0]          dir_s;
  logic [1:0]          eff_dx_s, eff_dy_s;
  vel_t                vx_new_s, vy_new_s, vx_ref_s, vy_ref_s;
  logic [COORD_W-1:0]  x_ref_s, y_ref_s;
  logic                hit_x_s, hit_y_s;

  assign ball_x    = ball_x_r;
  assign ball_y    = ball_y_r;
  assign ball_size = COORD_W'(BALL_SIZE);
  assign vel_x     = vel_x_r;
  assign vel_y     = vel_y_r;
  assign speed     = speed_r;
  assign bounce    = bounce_r;
  assign moving    = moving_r;

  // Key-press / tick decode and the velocity/position candidates for this tick
  always_comb begin
    tick_s      = sync2_r & ~prev_r;
    press_s     = (keycode != key_prev_r) && (keycode != 8'h00);
    dir_s       = decode_dir(keycode);
    dir_press_s = press_s & dir_s[4];
    space_s     = press_s && (keycode == 8'h2C);
    inc_s       = press_s && (keycode == 8'h2E);
    dec_s       = press_s && (keycode == 8'h2D);
    pend_any_s  = dir_press_s | pend_valid_r;
    eff_dx_s    = dir_press_s ? dir_s[3:2] : pend_dx_r;
    eff_dy_s    = dir_press_s ? dir_s[1:0] : pend_dy_r;
    step_s      = tick_s && ((state_r == ST_RUN) || ((state_r == ST_IDLE) && pend_any_s));
    if (pend_any_s) begin
      vx_new_s = scale_dir(eff_dx_s, speed_r);
      vy_new_s = scale_dir(eff_dy_s, speed_r);
    end else begin
      vx_new_s = scale_dir(sign_of(vel_x_r), speed_r);
      vy_new_s = scale_dir(sign_of(vel_y_r), speed_r);
    end
    {hit_x_s, vx_ref_s, x_ref_s} = reflect(ball_x_r, vx_new_s, X_LO, X_HI);
    {hit_y_s, vy_ref_s, y_ref_s} = reflect(ball_y_r, vy_new_s, Y_LO, Y_HI);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && pend_any_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (space_s) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (space_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // vsync synchroniser, edge register, key history and state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      prev_r     <= 1'b0;
      key_prev_r <= 8'h00;
      state_r    <= ST_IDLE;
      moving_r   <= 1'b0;
    end else begin
      sync1_r    <= frame_vs;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      key_prev_r <= keycode;
      state_r    <= state_s;
      moving_r   <= (state_s == ST_RUN);
    end
  end

  // Speed magnitude, saturating between 1 and SPEED_MAX
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      speed_r <= SPEED_W'(SPEED_INIT);
    end else if (inc_s && (speed_r < SPEED_W'(SPEED_MAX))) begin
      speed_r <= speed_r + 1'b1;
    end else if (dec_s && (speed_r > SPEED_W'(1))) begin
      speed_r <= speed_r - 1'b1;
    end
  end

  // Pending direction, motion update and bounce pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_valid_r <= 1'b0;
      pend_dx_r    <= 2'b00;
      pend_dy_r    <= 2'b00;
      ball_x_r     <= COORD_W'(X_START);
      ball_y_r     <= COORD_W'(Y_START);
      vel_x_r      <= '0;
      vel_y_r      <= '0;
      bounce_r     <= 1'b0;
    end else begin
      bounce_r <= step_s & (hit_x_s | hit_y_s);
      if (step_s) begin
        pend_valid_r <= 1'b0;
        ball_x_r     <= x_ref_s;
        ball_y_r     <= y_ref_s;
        vel_x_r      <= vx_ref_s;
        vel_y_r      <= vy_ref_s;
      end else if (dir_press_s) begin
        pend_valid_r <= 1'b1;
        pend_dx_r    <= dir_s[3:2];
        pend_dy_r    <= dir_s[1:0];
      end
    end
  end

endmodule
